// File: rtl/spi_s2p_rx_if.sv
// -----------------------------------------------------------------------------
// spi_s2p_rx_if
//   Bundle of the SPI receive front-end signals.
//
//   Raw SPI side : sck, cs (active low), mosi
//   Result side  : head_flag, data_out[DATA_W-1:0], data_valid, frame_err, busy
//
//   slave  : the receiver (samples SPI lines, drives results)
//   master : the SPI driver / observer (drives SPI lines, reads results)
// -----------------------------------------------------------------------------
interface spi_s2p_rx_if #(
  parameter int DATA_W = 14
);
  logic              sck;
  logic              cs;
  logic              mosi;
  logic              head_flag;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output sck, cs, mosi,
    input  head_flag, data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  sck, cs, mosi,
    output head_flag, data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_s2p_rx.sv
// -----------------------------------------------------------------------------
// spi_s2p_rx
//   SPI slave receive front-end. Synchronizes raw sck/cs/mosi into clk,
//   detects sck rising edges and deserializes an MSB-first frame made of a
//   HEAD_W-bit header followed by a DATA_W-bit data word.
//
//   Ports:
//     clk  : system clock, at least 4x the sck frequency
//     rst  : synchronous, active-high reset
//     bus  : spi_s2p_rx_if.slave
//              sck, cs (active low), mosi : raw asynchronous SPI inputs
//              head_flag  : 1 from header match until cs deasserts
//              data_out   : last successfully received data word
//              data_valid : one-clk pulse when data_out updates
//              frame_err  : one-clk pulse on aborted / bad frame
//              busy       : 1 whenever the FSM is not idle
//
//   Optional build macro SPI_S2P_PARITY_EN: the frame carries one trailing
//   even-parity bit over header+data; data is only accepted if it matches.
// -----------------------------------------------------------------------------
module spi_s2p_rx #(
  parameter int              DATA_W      = 14,
  parameter int              HEAD_W      = 2,
  parameter logic [HEAD_W-1:0] HEAD_PAT  = 2'b10,
  parameter int              SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_s2p_rx_if.slave  bus
);

  localparam int FRAME_W = HEAD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

`ifdef SPI_S2P_PARITY_EN
  // Whole header+data must be kept until the parity bit arrives.
  localparam int SHIFT_W = FRAME_W;
  localparam int REG_W   = FRAME_W;
`else
  // Only the data word is needed; its last bit comes straight from mosi.
  localparam int SHIFT_W = DATA_W;
  localparam int REG_W   = DATA_W - 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
`ifdef SPI_S2P_PARITY_EN
    ST_PARITY,
`endif
    ST_WAIT_CS
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers: one chain per stage holding {sck, cs, mosi} so all three
  // lines see identical latency and mosi stays aligned with its sck edge.
  // cs resets to 1 (deasserted).
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic                        sck_prev_reg;
  logic                        cs_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= {SYNC_STAGES{3'b010}};
      sck_prev_reg <= 1'b0;
      cs_prev_reg  <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], {bus.sck, bus.cs, bus.mosi}};
      sck_prev_reg <= sync_reg[SYNC_STAGES-1][2];
      cs_prev_reg  <= sync_reg[SYNC_STAGES-1][1];
    end
  end

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic cs_rise;

  assign sck_s    = sync_reg[SYNC_STAGES-1][2];
  assign cs_s     = sync_reg[SYNC_STAGES-1][1];
  assign mosi_s   = sync_reg[SYNC_STAGES-1][0];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign cs_rise  = cs_s & ~cs_prev_reg;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  logic [REG_W-1:0]   shift_reg;
  logic [SHIFT_W-1:0] shift_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               head_flag_reg;
  logic [DATA_W-1:0]  data_out_reg;
  logic               data_valid_reg;
  logic               frame_err_reg;
  logic               busy_reg;
  logic               head_last;
  logic               data_last;

  assign shift_next = {shift_reg[SHIFT_W-2:0], mosi_s};
  assign head_last  = (cnt_reg == CNT_W'(HEAD_W - 1));
  assign data_last  = (cnt_reg == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      head_flag_reg  <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (!cs_s) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_HEAD;
          end
        end

        ST_HEAD: begin
          // cs_rise is checked first so a coincident sck edge cannot finish
          // the frame after the master has already let go of cs.
          if (cs_rise) begin
            frame_err_reg <= 1'b1;
            head_flag_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (sck_rise) begin
            shift_reg <= shift_next[REG_W-1:0];
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (head_last) begin
              if (shift_next[HEAD_W-1:0] == HEAD_PAT) begin
                head_flag_reg <= 1'b1;
                cnt_reg       <= '0;
                state_reg     <= ST_DATA;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= ST_WAIT_CS;
              end
            end
          end
        end

        ST_DATA: begin
          if (cs_rise) begin
            frame_err_reg <= 1'b1;
            head_flag_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (sck_rise) begin
            shift_reg <= shift_next[REG_W-1:0];
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (data_last) begin
`ifdef SPI_S2P_PARITY_EN
              state_reg <= ST_PARITY;
`else
              data_out_reg   <= shift_next[DATA_W-1:0];
              data_valid_reg <= 1'b1;
              state_reg      <= ST_WAIT_CS;
`endif
            end
          end
        end

`ifdef SPI_S2P_PARITY_EN
        ST_PARITY: begin
          if (cs_rise) begin
            frame_err_reg <= 1'b1;
            head_flag_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (sck_rise) begin
            // Even parity: the parity bit equals the XOR of header+data.
            if ((^shift_reg) == mosi_s) begin
              data_out_reg   <= shift_reg[DATA_W-1:0];
              data_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= ST_WAIT_CS;
          end
        end
`endif

        ST_WAIT_CS: begin
          // Surplus sck edges are ignored here; only cs release matters.
          if (cs_s) begin
            head_flag_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          head_flag_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.head_flag  = head_flag_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.busy       = busy_reg;

endmodule
